// File: rtl/btn_debounce_toggle.sv
// ============================================================================
// Module      : btn_debounce_toggle
// Description : Four-button synchroniser/debouncer with per-button LED toggle
//               and single-cycle press strobes. Optional long-press clear of
//               all LEDs is enabled with the LONG_PRESS_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce_toggle #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 24000000,
    parameter int BTN_ACTIVE_LOW  = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN1,
    input  logic       BTN2,
    input  logic       BTN3,
    input  logic       BTN4,
    output logic       LED1,
    output logic       LED2,
    output logic       LED3,
    output logic       LED4,
    output logic [3:0] PRESS,
    output logic       LONG
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef LONG_PRESS_EN
    localparam int               HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);
`endif

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_cfg
        $error("btn_debounce_toggle: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
    end

    logic [3:0] w_btn;
    logic [3:0] w_p;
    logic [3:0] w_rise;
    logic [3:0] w_fire;

    logic [3:0] led_q, led_d;
    logic [3:0] press_q, press_d;
    logic       long_q, long_d;

    assign w_btn = {BTN4, BTN3, BTN2, BTN1};
    assign w_p   = w_btn ^ ((BTN_ACTIVE_LOW != 0) ? 4'hF : 4'h0);

    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic             s1_q, s2_q;
        logic             stable_q, stable_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // The counter only advances while the synchronised level disagrees
        // with the debounced state; any agreement restarts the run.
        always_comb begin
            stable_d = stable_q;
            cnt_d    = cnt_q + CNT_W'(1);
            if (s2_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
                cnt_d    = '0;
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                s1_q     <= 1'b0;
                s2_q     <= 1'b0;
                stable_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                s1_q     <= w_p[i];
                s2_q     <= s1_q;
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
            end
        end

        assign w_rise[i] = stable_d & ~stable_q;

`ifdef LONG_PRESS_EN
        logic [HOLD_W-1:0] hold_q, hold_d;

        // Saturating one past the firing value makes the long press one-shot.
        always_comb begin
            hold_d = hold_q;
            if (!stable_q) begin
                hold_d = '0;
            end else if (hold_q != HOLD_SAT) begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                hold_q <= '0;
            end else begin
                hold_q <= hold_d;
            end
        end

        assign w_fire[i] = stable_q && (hold_q == HOLD_LAST);
`else
        assign w_fire[i] = 1'b0;
`endif
    end

    // A long-press clear takes priority over any toggle on the same edge.
    always_comb begin
        led_d   = led_q ^ w_rise;
        press_d = w_rise;
        long_d  = |w_fire;
        if (|w_fire) begin
            led_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            led_q   <= '0;
            press_q <= '0;
            long_q  <= 1'b0;
        end else begin
            led_q   <= led_d;
            press_q <= press_d;
            long_q  <= long_d;
        end
    end

    assign LED1  = led_q[0];
    assign LED2  = led_q[1];
    assign LED3  = led_q[2];
    assign LED4  = led_q[3];
    assign PRESS = press_q;
    assign LONG  = long_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce_toggle.sv
// ============================================================================
// Module      : tb_btn_debounce_toggle
// Description : Directed self-checking bench for btn_debounce_toggle
//               (DEBOUNCE_CYCLES=4, LONG_CYCLES=20; LONG_PRESS_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_debounce_toggle;

    localparam int DEB  = 4;
    localparam int LONGC = 20;
`ifdef LONG_PRESS_EN
    localparam bit HAS_LONG = 1'b1;
`else
    localparam bit HAS_LONG = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] btn;
    logic [3:0] al_btn;

    logic       led1, led2, led3, led4, lng;
    logic [3:0] press;
    logic       al_led1, al_led2, al_led3, al_led4, al_lng;
    logic [3:0] al_press;

    logic [8:0] view;
    logic [8:0] al_view;

    int total = 0;
    int bad   = 0;
    int npress [4];
    int al_npress [4];
    int nlong = 0;

    always #5 CLK = ~CLK;

    btn_debounce_toggle #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONGC),
        .BTN_ACTIVE_LOW (0)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .BTN1 (btn[0]),
        .BTN2 (btn[1]),
        .BTN3 (btn[2]),
        .BTN4 (btn[3]),
        .LED1 (led1),
        .LED2 (led2),
        .LED3 (led3),
        .LED4 (led4),
        .PRESS(press),
        .LONG (lng)
    );

    btn_debounce_toggle #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONGC),
        .BTN_ACTIVE_LOW (1)
    ) dut_al (
        .CLK  (CLK),
        .RST  (RST),
        .BTN1 (al_btn[0]),
        .BTN2 (al_btn[1]),
        .BTN3 (al_btn[2]),
        .BTN4 (al_btn[3]),
        .LED1 (al_led1),
        .LED2 (al_led2),
        .LED3 (al_led3),
        .LED4 (al_led4),
        .PRESS(al_press),
        .LONG (al_lng)
    );

    // {LONG, PRESS[3:0], LED4..LED1}
    assign view    = {lng, press, led4, led3, led2, led1};
    assign al_view = {al_lng, al_press, al_led4, al_led3, al_led2, al_led1};

    task automatic tick();
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (press[i])    npress[i]++;
            if (al_press[i]) al_npress[i]++;
        end
        if (lng) nlong++;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%03h expected=%03h", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            npress[i]    = 0;
            al_npress[i] = 0;
        end
        RST    = 1'b1;
        btn    = 4'b0001;
        al_btn = 4'b1111;

        // Button held through reset: seen as inactive until reset releases
        tick();
        chk("reset_c1", view, 9'h000);
        tick();
        chk("reset_c2", view, 9'h000);
        chk("reset_al", al_view, 9'h000);
        RST = 1'b0;
        ticks(DEB);
        tick();
        chk("t1_before_press", view, 9'h000);
        tick();
        chk("t1_press", view, 9'h011);
        tick();
        chk("t1_strobe_clear", view, 9'h001);

        // Held indefinitely -> one press; release -> no change; second press
        ticks(10);
        chk("t2_held", view, 9'h001);
        chk_int("t2_one_press", npress[0], 1);
        btn[0] = 1'b0;
        ticks(10);
        chk("t2_release", view, 9'h001);
        btn[0] = 1'b1;
        ticks(DEB + 1);
        chk("t2_before_press2", view, 9'h001);
        tick();
        chk("t2_press2", view, 9'h010);
        tick();
        chk("t2_after_press2", view, 9'h000);
        chk_int("t2_two_presses", npress[0], 2);
        btn[0] = 1'b0;
        ticks(10);

        // Short pulse (one below threshold) and bounce
        btn[1] = 1'b1;
        ticks(DEB - 1);
        btn[1] = 1'b0;
        ticks(10);
        chk("t3_short_pulse", view, 9'h000);
        chk_int("t3_no_press2", npress[1], 0);
        for (int i = 0; i < 6; i++) begin
            btn[2] = ~i[0];
            tick();
        end
        btn[2] = 1'b1;
        ticks(DEB + 1);
        chk("t3_bounce_quiet", view, 9'h000);
        tick();
        chk("t3_bounce_press", view, 9'h044);
        tick();
        chk("t3_bounce_after", view, 9'h004);
        btn[2] = 1'b0;
        ticks(10);
        chk_int("t3_one_press3", npress[2], 1);

        // Simultaneous presses
        btn = 4'b1001;
        ticks(DEB + 1);
        chk("t4_before", view, 9'h004);
        tick();
        chk("t4_press", view, 9'h09D);
        tick();
        chk("t4_after", view, 9'h00D);
        btn = 4'b0000;
        ticks(10);
        chk("t4_release", view, 9'h00D);

        // Active-low instance
        al_btn[1] = 1'b0;
        ticks(DEB + 1);
        chk("t5_before", al_view, 9'h000);
        tick();
        chk("t5_press", al_view, 9'h022);
        tick();
        chk("t5_after", al_view, 9'h002);
        ticks(3);
        al_btn[1] = 1'b1;
        ticks(10);
        chk("t5_release", al_view, 9'h002);
        chk_int("t5_one_press", al_npress[1], 1);

        // Long press, LED3 set beforehand
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("t6_reset", view, 9'h000);
        btn[2] = 1'b1;
        ticks(DEB + 2);
        chk("t6_led3_press", view, 9'h044);
        btn[2] = 1'b0;
        ticks(10);
        nlong = 0;
        btn[1] = 1'b1;
        ticks(DEB + 2);
        chk("t6_led2_press", view, 9'h026);
        ticks(LONGC - 1);
        chk("t6_before_long", view, 9'h006);
        tick();
        chk("t6_long_edge", view, HAS_LONG ? 9'h100 : 9'h006);
        tick();
        chk("t6_long_after", view, HAS_LONG ? 9'h000 : 9'h006);
        ticks(13);
        chk_int("t6_one_long", nlong, HAS_LONG ? 1 : 0);
        btn[1] = 1'b0;
        ticks(10);
        chk("t6_release", view, HAS_LONG ? 9'h000 : 9'h006);

        // Reset mid-hold discards hold progress
        RST = 1'b1;
        tick();
        RST = 1'b0;
        nlong = 0;
        btn[1] = 1'b1;
        ticks(DEB + 2);
        chk("t6r_press", view, 9'h022);
        ticks(14);
        RST = 1'b1;
        tick();
        chk("t6r_reset", view, 9'h000);
        RST = 1'b0;
        ticks(DEB + 1);
        chk("t6r_before_repress", view, 9'h000);
        tick();
        chk("t6r_repress", view, 9'h022);
        ticks(10);
        btn[1] = 1'b0;
        ticks(10);
        chk("t6r_release", view, 9'h002);
        chk_int("t6r_no_long", nlong, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
